// File: rtl/ddr_addr_gen.sv
// Ring-buffer burst address generator for a DDR controller: write/read pointers, fill level, flags.
// Optional macro DDR_ADDR_GEN_OVERWRITE_EN: a write while full discards the oldest burst.
module ddr_addr_gen #(
    parameter int unsigned ADDR_WIDTH = 25,
    parameter int unsigned BURST_STEP = 4,
    parameter int unsigned RING_WORDS = 32'd1 << 24,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  phy_clk,
    input  logic                  rst_n,
    input  logic                  local_init_done,
    input  logic                  clear,
    input  logic                  wr_addr_up,
    input  logic                  rd_addr_up,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  read_en,
    output logic                  wr_full,
    output logic [ADDR_WIDTH:0]   fill_words,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned FW = ADDR_WIDTH + 1;

    localparam logic [FW-1:0]         STEP     = FW'(BURST_STEP);
    localparam logic [FW-1:0]         RING     = FW'(RING_WORDS);
    localparam logic [FW-1:0]         RING_END = FW'(BASE_ADDR) + FW'(RING_WORDS);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [1:0] {
        WAIT_INIT = 2'd0,
        RUN       = 2'd1,
        FLUSH     = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   wr_nxt;
    logic [ADDR_WIDTH-1:0]   rd_nxt;
    logic [FW-1:0]           fill_nxt;
    logic                    ovf_nxt;
    logic                    unf_nxt;
    logic                    read_en_nxt;
    logic                    wr_full_nxt;
    logic                    full;
    logic                    rd_ok;

    // Advance a pointer by one burst; reaching the ring end wraps straight to the base.
    function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
        logic [FW-1:0] sum;
        sum = {1'b0, p} + STEP;
        return (sum == RING_END) ? BASE : sum[ADDR_WIDTH-1:0];
    endfunction

    // State and datapath registers.
    always_ff @(posedge phy_clk) begin
        if (!rst_n) begin
            state      <= WAIT_INIT;
            wr_addr    <= BASE;
            rd_addr    <= BASE;
            fill_words <= '0;
            read_en    <= 1'b0;
            wr_full    <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_addr    <= wr_nxt;
            rd_addr    <= rd_nxt;
            fill_words <= fill_nxt;
            read_en    <= read_en_nxt;
            wr_full    <= wr_full_nxt;
            overflow   <= ovf_nxt;
            underflow  <= unf_nxt;
        end
    end

    // Next-state, pointer and flag logic.
    always_comb begin
        state_nxt = state;
        wr_nxt    = wr_addr;
        rd_nxt    = rd_addr;
        fill_nxt  = fill_words;
        ovf_nxt   = overflow;
        unf_nxt   = underflow;
        full      = (fill_words == RING);
        rd_ok     = (fill_words >= STEP);

        unique case (state)
            WAIT_INIT: begin
                wr_nxt   = BASE;
                rd_nxt   = BASE;
                fill_nxt = '0;
                if (local_init_done) begin
                    state_nxt = RUN;
                end
            end

            RUN: begin
                // A flush request discards any pulse arriving with it.
                if (clear) begin
                    state_nxt = FLUSH;
                end else if (local_init_done) begin
                    if (rd_addr_up && !rd_ok) begin
                        unf_nxt = 1'b1;
                    end
                    if (wr_addr_up && rd_addr_up && rd_ok) begin
                        wr_nxt = next_ptr(wr_addr);
                        rd_nxt = next_ptr(rd_addr);
                    end else if (wr_addr_up && !full) begin
                        wr_nxt   = next_ptr(wr_addr);
                        fill_nxt = fill_words + STEP;
                    end else if (wr_addr_up) begin
                        ovf_nxt = 1'b1;
`ifdef DDR_ADDR_GEN_OVERWRITE_EN
                        wr_nxt = next_ptr(wr_addr);
                        rd_nxt = next_ptr(rd_addr);
`endif
                    end else if (rd_addr_up && rd_ok) begin
                        rd_nxt   = next_ptr(rd_addr);
                        fill_nxt = fill_words - STEP;
                    end
                end
            end

            FLUSH: begin
                wr_nxt    = BASE;
                rd_nxt    = BASE;
                fill_nxt  = '0;
                ovf_nxt   = 1'b0;
                unf_nxt   = 1'b0;
                state_nxt = RUN;
            end

            default: begin
                state_nxt = WAIT_INIT;
            end
        endcase

        if (!local_init_done) begin
            state_nxt = WAIT_INIT;
        end

        // Status flags registered from next-cycle values so they match state and fill exactly.
        read_en_nxt = (state_nxt == RUN) && (fill_nxt >= STEP);
        wr_full_nxt = (fill_nxt == RING);
    end

endmodule

// File: tb/tb_ddr_addr_gen.sv
// Directed table-driven bench for ddr_addr_gen (RING_WORDS=16, BURST_STEP=4, BASE_ADDR=0x100).
module tb_ddr_addr_gen;

    localparam int unsigned AW = 25;

`ifdef DDR_ADDR_GEN_OVERWRITE_EN
    localparam logic [AW-1:0] OW = 25'h104;
`else
    localparam logic [AW-1:0] OW = 25'h100;
`endif

    logic          phy_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          local_init_done = 1'b0;
    logic          clear = 1'b0;
    logic          wr_addr_up = 1'b0;
    logic          rd_addr_up = 1'b0;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          read_en;
    logic          wr_full;
    logic [AW:0]   fill_words;
    logic          overflow;
    logic          underflow;

    int total = 0;
    int bad = 0;

    ddr_addr_gen #(
        .ADDR_WIDTH(AW),
        .BURST_STEP(4),
        .RING_WORDS(16),
        .BASE_ADDR (32'h100)
    ) dut (
        .phy_clk        (phy_clk),
        .rst_n          (rst_n),
        .local_init_done(local_init_done),
        .clear          (clear),
        .wr_addr_up     (wr_addr_up),
        .rd_addr_up     (rd_addr_up),
        .wr_addr        (wr_addr),
        .rd_addr        (rd_addr),
        .read_en        (read_en),
        .wr_full        (wr_full),
        .fill_words     (fill_words),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    always #5 phy_clk = ~phy_clk;

    typedef struct {
        logic          rst;
        logic          init;
        logic          clr;
        logic          wr;
        logic          rd;
        logic [AW-1:0] wa;
        logic [AW-1:0] ra;
        logic [AW:0]   fw;
        logic          re;
        logic          full;
        logic          ovf;
        logic          unf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic i, input logic c, input logic w, input logic d,
                       input logic [AW-1:0] wa, input logic [AW-1:0] ra, input int fw,
                       input logic re, input logic full, input logic ovf, input logic unf);
        vec_t v;
        v.rst = r; v.init = i; v.clr = c; v.wr = w; v.rd = d;
        v.wa = wa; v.ra = ra; v.fw = (AW+1)'(fw);
        v.re = re; v.full = full; v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs at the falling edge, sample #1 after the rising edge.
    task automatic step(input logic r, input logic i, input logic c, input logic w, input logic d);
        @(negedge phy_clk);
        rst_n = r; local_init_done = i; clear = c; wr_addr_up = w; rd_addr_up = d;
        @(posedge phy_clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    initial begin
        // rst init clr wr rd | wa ra fill re full ovf unf
        for (int k = 0; k < 3; k++) add(0,0,0,1,0, 'h100,'h100, 0, 0,0,0,0);
        for (int k = 0; k < 5; k++) add(1,0,0,1,0, 'h100,'h100, 0, 0,0,0,0);
        add(1,1,0,0,0, 'h100,'h100, 0, 0,0,0,0);
        add(1,1,0,1,0, 'h104,'h100, 4, 1,0,0,0);
        add(1,1,0,1,0, 'h108,'h100, 8, 1,0,0,0);
        add(1,1,0,0,1, 'h108,'h104, 4, 1,0,0,0);
        add(1,1,0,0,1, 'h108,'h108, 0, 0,0,0,0);
        add(1,1,1,0,0, 'h108,'h108, 0, 0,0,0,0);
        add(1,1,0,0,0, 'h100,'h100, 0, 0,0,0,0);
        add(1,1,0,1,0, 'h104,'h100, 4, 1,0,0,0);
        add(1,1,0,1,0, 'h108,'h100, 8, 1,0,0,0);
        add(1,1,0,1,0, 'h10C,'h100,12, 1,0,0,0);
        add(1,1,0,1,0, 'h100,'h100,16, 1,1,0,0);
        add(1,1,0,1,0, OW,    OW,   16, 1,1,1,0);
        add(1,1,1,0,0, OW,    OW,   16, 0,1,1,0);
        add(1,1,0,0,0, 'h100,'h100, 0, 0,0,0,0);
        add(1,1,0,1,0, 'h104,'h100, 4, 1,0,0,0);
        add(1,1,0,1,0, 'h108,'h100, 8, 1,0,0,0);
        add(1,1,0,1,0, 'h10C,'h100,12, 1,0,0,0);
        add(1,1,0,1,0, 'h100,'h100,16, 1,1,0,0);
        add(1,1,0,1,1, 'h104,'h104,16, 1,1,0,0);
        add(1,1,0,0,1, 'h104,'h108,12, 1,0,0,0);
        add(1,1,0,0,1, 'h104,'h10C, 8, 1,0,0,0);
        add(1,1,0,0,1, 'h104,'h100, 4, 1,0,0,0);
        add(1,1,0,0,1, 'h104,'h104, 0, 0,0,0,0);
        add(1,1,0,0,1, 'h104,'h104, 0, 0,0,0,1);
        add(1,1,1,1,0, 'h104,'h104, 0, 0,0,0,1);
        add(1,1,0,0,0, 'h100,'h100, 0, 0,0,0,0);
        add(1,1,0,1,0, 'h104,'h100, 4, 1,0,0,0);
        add(1,1,0,1,0, 'h108,'h100, 8, 1,0,0,0);
        add(0,1,0,0,0, 'h100,'h100, 0, 0,0,0,0);
        add(1,1,0,1,0, 'h100,'h100, 0, 0,0,0,0);
        add(1,1,0,1,0, 'h104,'h100, 4, 1,0,0,0);
        add(1,0,0,0,0, 'h104,'h100, 4, 0,0,0,0);
        add(1,0,0,0,0, 'h100,'h100, 0, 0,0,0,0);

        foreach (vecs[n]) begin
            step(vecs[n].rst, vecs[n].init, vecs[n].clr, vecs[n].wr, vecs[n].rd);
            total++;
            if (wr_addr !== vecs[n].wa || rd_addr !== vecs[n].ra || fill_words !== vecs[n].fw ||
                read_en !== vecs[n].re || wr_full !== vecs[n].full ||
                overflow !== vecs[n].ovf || underflow !== vecs[n].unf) begin
                bad++;
                $display("FAIL vec%0d: got wa=%h ra=%h fill=%0d re=%b full=%b ovf=%b unf=%b, want wa=%h ra=%h fill=%0d re=%b full=%b ovf=%b unf=%b",
                         n, wr_addr, rd_addr, fill_words, read_en, wr_full, overflow, underflow,
                         vecs[n].wa, vecs[n].ra, vecs[n].fw, vecs[n].re, vecs[n].full,
                         vecs[n].ovf, vecs[n].unf);
            end
        end

        // Overflow stays sticky across idle cycles until a flush clears it.
        step(1,1,0,0,0);
        for (int k = 0; k < 4; k++) step(1,1,0,1,0);
        chk("full_after_4", int'(wr_full), 1);
        step(1,1,0,1,0);
        chk("ovf_set", int'(overflow), 1);
        for (int k = 0; k < 3; k++) begin
            step(1,1,0,0,0);
            chk("ovf_sticky", int'(overflow), 1);
            chk("fill_hold", int'(fill_words), 16);
        end
        chk("unf_clear", int'(underflow), 0);
        step(1,1,1,0,1);
        chk("flush_read_en", int'(read_en), 0);
        chk("flush_full_hold", int'(wr_full), 1);
        chk("flush_ovf_hold", int'(overflow), 1);
        step(1,1,0,0,0);
        chk("post_flush_ovf", int'(overflow), 0);
        chk("post_flush_fill", int'(fill_words), 0);
        chk("post_flush_wa", int'(wr_addr), 'h100);
        chk("post_flush_ra", int'(rd_addr), 'h100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr_addr_gen.md
DDR_ADDR_GEN -- requirements
Module: ddr_addr_gen

Interface
- REQ-001 SHALL have parameter ADDR_WIDTH, default 25: DDR local word-address width.
- REQ-002 SHALL have parameter BURST_STEP, default 4: words per DDR burst and the pointer increment per burst.
- REQ-003 SHALL have parameter RING_WORDS, default 2^24: ring-buffer size in words; a power of two, a multiple of BURST_STEP, and no larger than 2^ADDR_WIDTH.
- REQ-004 SHALL have parameter BASE_ADDR, default 0: first word address of the ring; a multiple of BURST_STEP.
- REQ-005 phy_clk, input, 1: the single clock, which is the DDR controller half-rate clock.
- REQ-006 rst_n, input, 1: reset, synchronous and active-low.
- REQ-007 local_init_done, input, 1: DDR controller calibration complete.
- REQ-008 clear, input, 1: synchronous flush request.
- REQ-009 wr_addr_up, input, 1: one-cycle pulse; one write burst has been accepted by the burst engine.
- REQ-010 rd_addr_up, input, 1: one-cycle pulse; one read burst has been accepted by the burst engine.
- REQ-011 wr_addr, output, ADDR_WIDTH: start address of the next write burst.
- REQ-012 rd_addr, output, ADDR_WIDTH: start address of the next read burst.
- REQ-013 read_en, output, 1: at least one full burst of stored data is available to read.
- REQ-014 wr_full, output, 1: fill level equals RING_WORDS.
- REQ-015 fill_words, output, ADDR_WIDTH+1: number of words written but not yet read.
- REQ-016 overflow, output, 1: sticky flag; a write pulse arrived while full.
- REQ-017 underflow, output, 1: sticky flag; a read pulse arrived with fewer than BURST_STEP words stored.

Function
- REQ-018 SHALL implement FSM states WAIT_INIT, RUN and FLUSH.
  - WAIT_INIT -> RUN when local_init_done=1.
  - RUN -> FLUSH when clear=1.
  - FLUSH -> RUN after exactly one cycle.
  - Any state -> WAIT_INIT when local_init_done=0.
- REQ-019 In WAIT_INIT and FLUSH: pointers SHALL load BASE_ADDR, fill_words SHALL load 0, and wr_addr_up/rd_addr_up SHALL be ignored.
- REQ-020 In RUN, on wr_addr_up (not full):
  - wr_addr SHALL advance by BURST_STEP on the next phy_clk edge.
  - fill_words SHALL increase by BURST_STEP.
- REQ-021 In RUN, on rd_addr_up with fill_words >= BURST_STEP:
  - rd_addr SHALL advance by BURST_STEP.
  - fill_words SHALL decrease by BURST_STEP.
- REQ-022 Pointer wrap: a pointer that would reach BASE_ADDR+RING_WORDS SHALL load BASE_ADDR instead; there SHALL be no dead slot.
- REQ-023 Simultaneous valid wr_addr_up and rd_addr_up SHALL advance both pointers and leave fill_words unchanged, including when full (no overflow in that case).
- REQ-024 rd_addr_up with fill_words < BURST_STEP SHALL be ignored and SHALL set underflow.
- REQ-025 Output timing, all registered or derived from registers only; no combinational path from any input to any output:
  - read_en = (state==RUN) and (fill_words >= BURST_STEP).
  - wr_full = (fill_words == RING_WORDS).
- REQ-026 overflow and underflow SHALL clear only on rst_n=0 or in the FLUSH state.
- REQ-027 clear asserted in the same cycle as an up pulse: the flush SHALL win and the pulse SHALL be discarded.

Reset
- REQ-028 While rst_n=0 at a phy_clk edge, the block SHALL load:
  - state=WAIT_INIT;
  - wr_addr=rd_addr=BASE_ADDR;
  - fill_words=0;
  - read_en=0, wr_full=0, overflow=0, underflow=0.
- REQ-029 Deasserting rst_n mid-operation SHALL restart from WAIT_INIT; no prior pointer state SHALL be retained.

Configuration
- REQ-030 Macro DDR_ADDR_GEN_OVERWRITE_EN SHALL select the behaviour of wr_addr_up while full and not simultaneous with rd_addr_up.
  - Defined: wr_addr and rd_addr SHALL both advance by BURST_STEP (the oldest burst is discarded), fill_words SHALL stay at RING_WORDS, and overflow SHALL be set.
  - Undefined: the pulse SHALL be ignored (no pointer or fill change) and overflow SHALL be set.

Verification (bench uses RING_WORDS=16, BURST_STEP=4, BASE_ADDR=0x100)
- REQ-031 Init gating: rst_n low 3 cycles, local_init_done=0, 5 wr_addr_up pulses -> wr_addr=0x100, fill_words=0, read_en=0. Then raise local_init_done -> RUN on the next cycle.
- REQ-032 Basic flow: 2 wr_addr_up -> wr_addr=0x108, fill_words=8, read_en=1. Then 2 rd_addr_up -> rd_addr=0x108, fill_words=0, read_en=0 one cycle after the second pulse.
- REQ-033 Wrap/full: 4 wr_addr_up -> wr_addr=0x100 (wrapped), fill_words=16, wr_full=1. A 5th pulse:
  - without the macro -> no pointer change, overflow=1;
  - with the macro -> rd_addr=0x104, fill_words=16, overflow=1.
- REQ-034 Simultaneous: at fill_words=16, wr_addr_up and rd_addr_up in the same cycle -> both pointers +4, fill_words=16, overflow stays 0.
- REQ-035 Underflow/flush: rd_addr_up at fill_words=0 -> rd_addr unchanged, underflow=1. Then clear together with wr_addr_up -> one FLUSH cycle, pointers=0x100, fill_words=0, underflow=0.
- REQ-036 Mid-run reset: at fill_words=8, drive rst_n=0 for 1 cycle -> all outputs at their reset values on the next edge, state=WAIT_INIT.
